// File: rtl/rgb_scan_pkg.sv
// Shared state encodings, colour-channel layout and BCM timing helpers for the
// HUB75 scan driver.
package rgb_scan_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE    = 3'd0;
    localparam state_t S_SHIFT   = 3'd1;
    localparam state_t S_BLANK   = 3'd2;
    localparam state_t S_LATCH   = 3'd3;
    localparam state_t S_DISPLAY = 3'd4;

    // Channel index inside a {R,G,B} pixel word; B occupies the low slice.
    localparam int CH_B = 0;
    localparam int CH_G = 1;
    localparam int CH_R = 2;

    function automatic int chan_lsb(input int ch, input int bpc);
        return ch * bpc;
    endfunction

    // Binary-weighted on-time of bit plane b.
    function automatic int disp_len(input int base, input int b);
        return base << b;
    endfunction

endpackage

// File: rtl/rgb_bitplane_sel.sv
// Picks bit 'plane' of each colour channel out of a packed {R,G,B} pixel word.
module rgb_bitplane_sel
    import rgb_scan_pkg::*;
#(
    parameter int BPC  = 4,
    parameter int PL_W = 2
) (
    input  logic [3*BPC-1:0] word,
    input  logic [PL_W-1:0]  plane,
    output logic [2:0]       bits
);

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_chan
            assign bits[gi] = |(word[chan_lsb(gi, BPC) +: BPC] & (BPC'(1) << plane));
        end
    endgenerate

endmodule

// File: rtl/rgb_matrix_scan.sv
// HUB75 scan driver: shift one bit plane per pass, latch it, then show it for a
// binary-weighted time. Define RGB_SCAN_DIM_EN to add the brightness input.
module rgb_matrix_scan
    import rgb_scan_pkg::*;
#(
    parameter int COLS      = 32,
    parameter int ROW_BITS  = 3,
    parameter int BPC       = 4,
    parameter int CLK_DIV   = 1,
    parameter int DISP_BASE = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              enable,
`ifdef RGB_SCAN_DIM_EN
    input  logic [7:0]                        brightness,
`endif
    output logic                              rd_en,
    output logic [ROW_BITS+$clog2(COLS)-1:0]  rd_addr,
    input  logic [3*BPC-1:0]                  rd_data_top,
    input  logic [3*BPC-1:0]                  rd_data_bot,
    output logic                              sclk,
    output logic                              latch,
    output logic                              blank,
    output logic [2:0]                        LED_Top,
    output logic [2:0]                        LED_Bottom,
    output logic [ROW_BITS-1:0]               row_select,
    output logic                              frame_done
);

    localparam int COL_W    = $clog2(COLS);
    localparam int LOW_LEN  = (CLK_DIV < 2) ? 2 : CLK_DIV;
    localparam int PER      = LOW_LEN + CLK_DIV;
    localparam int PH_W     = $clog2(PER);
    localparam int PL_W     = (BPC > 1) ? $clog2(BPC) : 1;
    localparam int DC_W     = $clog2((DISP_BASE << (BPC - 1)) + 1);

    state_t                state_reg;
    logic [PH_W-1:0]       ph_reg;
    logic [COL_W-1:0]      col_reg;
    logic [ROW_BITS-1:0]   row_reg;
    logic [PL_W-1:0]       plane_reg;
    logic [DC_W-1:0]       dcnt_reg;
    logic                  en_reg;
    logic [2:0]            led_top_reg;
    logic [2:0]            led_bot_reg;
    logic [ROW_BITS-1:0]   row_sel_reg;

    logic [2:0]            top_bits;
    logic [2:0]            bot_bits;
    logic [DC_W-1:0]       disp_len_cur;
    logic                  disp_last;
    logic                  plane_last;
    logic                  row_last;

    rgb_bitplane_sel #(.BPC(BPC), .PL_W(PL_W)) u_sel_top (
        .word  (rd_data_top),
        .plane (plane_reg),
        .bits  (top_bits)
    );

    rgb_bitplane_sel #(.BPC(BPC), .PL_W(PL_W)) u_sel_bot (
        .word  (rd_data_bot),
        .plane (plane_reg),
        .bits  (bot_bits)
    );

    assign disp_len_cur = DC_W'(disp_len(DISP_BASE, int'(plane_reg)));
    assign disp_last    = (dcnt_reg == disp_len_cur - DC_W'(1));
    assign plane_last   = (plane_reg == PL_W'(BPC - 1));
    assign row_last     = (row_reg == {ROW_BITS{1'b1}});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= S_IDLE;
            ph_reg      <= '0;
            col_reg     <= '0;
            row_reg     <= '0;
            plane_reg   <= '0;
            dcnt_reg    <= '0;
            en_reg      <= 1'b0;
            led_top_reg <= '0;
            led_bot_reg <= '0;
            row_sel_reg <= '0;
        end else begin
            en_reg <= enable;
            case (state_reg)
                S_IDLE: begin
                    if (en_reg) begin
                        state_reg <= S_SHIFT;
                        ph_reg    <= '0;
                        col_reg   <= '0;
                    end
                end
                S_SHIFT: begin
                    // Read data is valid in the second low cycle; capture it there.
                    if (ph_reg == PH_W'(1)) begin
                        led_top_reg <= top_bits;
                        led_bot_reg <= bot_bits;
                    end
                    if (ph_reg == PH_W'(PER - 1)) begin
                        ph_reg <= '0;
                        if (col_reg == COL_W'(COLS - 1)) begin
                            col_reg   <= '0;
                            state_reg <= S_BLANK;
                        end else begin
                            col_reg <= col_reg + COL_W'(1);
                        end
                    end else begin
                        ph_reg <= ph_reg + PH_W'(1);
                    end
                end
                S_BLANK: begin
                    state_reg   <= S_LATCH;
                    row_sel_reg <= row_reg;
                end
                S_LATCH: begin
                    state_reg <= S_DISPLAY;
                    dcnt_reg  <= '0;
                end
                S_DISPLAY: begin
                    if (disp_last) begin
                        dcnt_reg <= '0;
                        if (plane_last) begin
                            plane_reg <= '0;
                            row_reg   <= row_reg + ROW_BITS'(1);
                        end else begin
                            plane_reg <= plane_reg + PL_W'(1);
                        end
                        state_reg <= en_reg ? S_SHIFT : S_IDLE;
                    end else begin
                        dcnt_reg <= dcnt_reg + DC_W'(1);
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

`ifdef RGB_SCAN_DIM_EN
    logic [DC_W-1:0]  on_len_reg;
    logic [DC_W+7:0]  dim_prod;

    assign dim_prod = {8'd0, disp_len_cur} * {{DC_W{1'b0}}, brightness};

    // Brightness is captured on the way into LATCH so it cannot change mid-plane.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            on_len_reg <= '0;
        end else if (state_reg == S_BLANK) begin
            on_len_reg <= DC_W'(dim_prod >> 8);
        end
    end

    assign blank = !((state_reg == S_DISPLAY) && (dcnt_reg < on_len_reg));
`else
    assign blank = (state_reg != S_DISPLAY);
`endif

    assign rd_en      = (state_reg == S_SHIFT) && (ph_reg == '0);
    assign rd_addr    = {row_reg, col_reg};
    assign sclk       = (state_reg == S_SHIFT) && (ph_reg >= PH_W'(LOW_LEN));
    assign latch      = (state_reg == S_LATCH);
    assign LED_Top    = led_top_reg;
    assign LED_Bottom = led_bot_reg;
    assign row_select = row_sel_reg;
    assign frame_done = (state_reg == S_DISPLAY) && disp_last && plane_last && row_last;

endmodule

// File: tb/tb_rgb_matrix_scan.sv
// Directed scoreboard bench for rgb_matrix_scan (4 cols, 2 rows, 2 planes).
module tb_rgb_matrix_scan;

    localparam int COLS      = 4;
    localparam int ROW_BITS  = 1;
    localparam int BPC       = 2;
    localparam int CLK_DIV   = 1;
    localparam int DISP_BASE = 4;
    localparam int AW        = ROW_BITS + $clog2(COLS);

`ifdef RGB_SCAN_DIM_EN
    localparam int BRIGHT = 128;
    logic [7:0] brightness;
`endif

    logic                 clk;
    logic                 reset;
    logic                 enable;
    logic                 rd_en;
    logic [AW-1:0]        rd_addr;
    logic [3*BPC-1:0]     rd_data_top;
    logic [3*BPC-1:0]     rd_data_bot;
    logic                 sclk;
    logic                 latch;
    logic                 blank;
    logic [2:0]           LED_Top;
    logic [2:0]           LED_Bottom;
    logic [ROW_BITS-1:0]  row_select;
    logic                 frame_done;

    logic [5:0]  fb_top [8];
    logic [5:0]  fb_bot [8];
    logic [31:0] q_addr [$];
    logic [31:0] q_led  [$];
    logic [31:0] q_row  [$];
    logic [31:0] q_disp [$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int first_rd_cyc = 0;
    int last_rd_cyc = 0;
    int rises = 0;
    int rise_total = 0;
    int run_len = 0;
    int disp_runs = 0;
    int fd_count = 0;
    int act = 0;
    int lat = 0;
    bit mon_on = 0;
    logic sclk_prev = 1'b0;
    logic latch_prev = 1'b0;
    logic [31:0] led_at_rise = '0;
    logic [31:0] cur_row = '0;
    logic [2:0]  first_top_p0 = '0;
    logic [2:0]  first_top_p1 = '0;

    rgb_matrix_scan #(
        .COLS(COLS), .ROW_BITS(ROW_BITS), .BPC(BPC),
        .CLK_DIV(CLK_DIV), .DISP_BASE(DISP_BASE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
`ifdef RGB_SCAN_DIM_EN
        .brightness  (brightness),
`endif
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data_top (rd_data_top),
        .rd_data_bot (rd_data_bot),
        .sclk        (sclk),
        .latch       (latch),
        .blank       (blank),
        .LED_Top     (LED_Top),
        .LED_Bottom  (LED_Bottom),
        .row_select  (row_select),
        .frame_done  (frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Framebuffer with one-cycle registered read.
    always @(posedge clk) begin
        if (rd_en) begin
            rd_data_top <= fb_top[rd_addr];
            rd_data_bot <= fb_bot[rd_addr];
        end
    end

    function automatic logic [2:0] plane_bits(input logic [5:0] w, input int p);
        logic [5:0] t;
        t = w >> p;
        return {t[4], t[2], t[0]};
    endfunction

    function automatic int exp_on(input int len);
`ifdef RGB_SCAN_DIM_EN
        return (len * BRIGHT) >> 8;
`else
        return len;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_plane(input int r, input int p);
        int a;
        for (int c = 0; c < COLS; c++) begin
            a = r * COLS + c;
            q_addr.push_back(32'(a));
            q_led.push_back(32'({plane_bits(fb_top[a], p), plane_bits(fb_bot[a], p)}));
        end
        q_row.push_back(32'(r));
        q_disp.push_back(32'(exp_on(DISP_BASE << p)));
    endtask

    task automatic step();
        logic [31:0] e;
        @(negedge clk);
        cyc++;
        if (mon_on) begin
            if (rd_en) begin
                check("rd_en_expected", 32'(q_addr.size() > 0), 32'd1);
                if (q_addr.size() > 0) begin
                    e = q_addr.pop_front();
                    check("rd_addr", 32'(rd_addr), e);
                    if (first_rd_cyc == 0) first_rd_cyc = cyc;
                    else if (e[1:0] != 2'd0) check("rd_spacing", 32'(cyc - last_rd_cyc), 32'd3);
                    last_rd_cyc = cyc;
                end
            end
            if (sclk && !sclk_prev) begin
                check("sclk_rise_expected", 32'(q_led.size() > 0), 32'd1);
                if (q_led.size() > 0) begin
                    e = q_led.pop_front();
                    check("led_at_rise", 32'({LED_Top, LED_Bottom}), e);
                end
                if (rise_total == 0) first_top_p0 = LED_Top;
                if (rise_total == 4) first_top_p1 = LED_Top;
                rise_total++;
                rises++;
                led_at_rise = 32'({LED_Top, LED_Bottom});
            end
            if (!sclk && sclk_prev) check("led_hold", 32'({LED_Top, LED_Bottom}), led_at_rise);
            if (latch) begin
                check("latch_width", 32'(latch_prev), 32'd0);
                check("sclk_per_plane", 32'(rises), 32'd4);
                check("blank_in_latch", 32'(blank), 32'd1);
                rises = 0;
                check("latch_expected", 32'(q_row.size() > 0), 32'd1);
                if (q_row.size() > 0) begin
                    cur_row = q_row.pop_front();
                    check("row_select_at_latch", 32'(row_select), cur_row);
                end
            end
            if (!blank) begin
                run_len++;
                check("row_stable_lit", 32'(row_select), cur_row);
            end else if (run_len > 0) begin
                check("display_expected", 32'(q_disp.size() > 0), 32'd1);
                if (q_disp.size() > 0) begin
                    e = q_disp.pop_front();
                    check("display_len", 32'(run_len), e);
                end
                run_len = 0;
                disp_runs++;
            end
            if (frame_done) fd_count++;
        end
        sclk_prev  = sclk;
        latch_prev = latch;
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
`ifdef RGB_SCAN_DIM_EN
        brightness = 8'(BRIGHT);
`endif
        fb_top[0] = 6'b10_01_11;
        fb_bot[0] = 6'b01_11_00;
        for (int a = 1; a < 8; a++) begin
            fb_top[a] = 6'(a * 11 + 5);
            fb_bot[a] = 6'(a * 7 + 42);
        end

        repeat (3) @(negedge clk);
        enable = 1'b1;
        check("reset_sclk",       32'(sclk), 32'd0);
        check("reset_latch",      32'(latch), 32'd0);
        check("reset_blank",      32'(blank), 32'd1);
        check("reset_led_top",    32'(LED_Top), 32'd0);
        check("reset_led_bot",    32'(LED_Bottom), 32'd0);
        check("reset_row_select", 32'(row_select), 32'd0);
        check("reset_rd_en",      32'(rd_en), 32'd0);
        check("reset_rd_addr",    32'(rd_addr), 32'd0);
        check("reset_frame_done", 32'(frame_done), 32'd0);

        for (int r = 0; r < 2; r++)
            for (int p = 0; p < BPC; p++)
                push_plane(r, p);
        push_plane(0, 0);
        mon_on = 1'b1;

        @(negedge clk);
        reset = 1'b0;
        cyc = 0;

        for (int i = 0; i < 400 && fd_count == 0; i++) step();
        check("frame_done_seen", 32'(fd_count), 32'd1);
        check("first_rd_cycle", 32'(first_rd_cyc), 32'd2);
        check("pix0_plane0_top", 32'(first_top_p0), 32'(3'b011));
        check("pix0_plane1_top", 32'(first_top_p1), 32'(3'b101));
        step();
        check("rd_addr_wrap", 32'({rd_en, rd_addr}), 32'({1'b1, 3'b000}));

        repeat (4) step();
        enable = 1'b0;
        for (int i = 0; i < 200 && disp_runs < 5; i++) step();
        check("runs_before_idle", 32'(disp_runs), 32'd5);
        act = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (rd_en || sclk || !blank) act++;
        end
        check("idle_quiet", 32'(act), 32'd0);
        check("q_addr_drained", 32'(q_addr.size()), 32'd0);
        check("q_led_drained",  32'(q_led.size()), 32'd0);
        check("q_row_drained",  32'(q_row.size()), 32'd0);
        check("q_disp_drained", 32'(q_disp.size()), 32'd0);
        check("frame_done_single", 32'(fd_count), 32'd1);

        push_plane(0, 1);
        enable = 1'b1;
        for (int i = 0; i < 200 && run_len < 3; i++) step();
        check("resume_lit", 32'(run_len), 32'd3);
        mon_on = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("async_blank",   32'(blank), 32'd1);
        check("async_sclk",    32'(sclk), 32'd0);
        check("async_rd_en",   32'(rd_en), 32'd0);
        check("async_latch",   32'(latch), 32'd0);
        check("async_led_top", 32'(LED_Top), 32'd0);
        check("resume_addr_drained", 32'(q_addr.size()), 32'd0);
        check("resume_row_drained",  32'(q_row.size()), 32'd0);

`ifdef RGB_SCAN_DIM_EN
        @(negedge clk);
        brightness = 8'd0;
        reset = 1'b0;
        act = 0;
        lat = 0;
        for (int i = 0; i < 150; i++) begin
            step();
            if (!blank) act++;
            if (latch) lat++;
        end
        check("dim_zero_dark", 32'(act), 32'd0);
        check("dim_zero_latched", 32'(lat > 0), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
